aes_cipher_iter: RTL and testbench
==================================

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 SHALL have parameter Nk, default 8: key length in 32-bit words; legal values 4, 6, 8.
REQ-002 SHALL have parameter Nr, default 14: number of rounds; SHALL equal Nk+6.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: data_in and round_keys are valid.
REQ-006 SHALL have port in_ready, output, 1: core accepts a block this cycle.
REQ-007 SHALL have port data_in, input, 128: plaintext, byte 0 in bits [127:120].
REQ-008 SHALL have port round_keys, input, 128*(Nr+1): expanded key as produced by keyExpansion; round key r occupies bits [128*(Nr+1)-1-128*r -: 128].
REQ-009 SHALL have port out_valid, output, 1: data_out holds a finished ciphertext.
REQ-010 SHALL have port out_ready, input, 1: consumer takes data_out.
REQ-011 SHALL have port data_out, output, 128: ciphertext, same byte order as data_in.
REQ-012 SHALL have port busy, output, 1: high in ROUND state.

Function
REQ-013 SHALL implement an FSM with states IDLE, ROUND and DONE.
REQ-014 IDLE: in_ready=1; on in_valid the FSM SHALL load state <= data_in XOR rk0, set round counter to 1 and go to ROUND.
REQ-015 ROUND: each edge SHALL apply one round (SubBytes, ShiftRows, MixColumns, AddRoundKey rk[cnt]) and increment cnt.
REQ-016 The round with cnt==Nr SHALL omit MixColumns, load the result into data_out and go to DONE.
REQ-017 Latency SHALL be exactly Nr cycles: out_valid rises Nr rising edges after the accept edge (14 for Nr=14, 10 for Nr=10).
REQ-018 DONE: out_valid=1, data_out stable, in_ready=0; on out_ready the FSM SHALL go to IDLE with out_valid=0 on the next cycle.
REQ-019 in_valid together with out_ready in DONE SHALL NOT be accepted; the earliest next accept is the cycle after the return to IDLE.
REQ-020 in_valid and data_in SHALL be ignored outside IDLE.
REQ-021 Without key latching (REQ-026), round_keys SHALL be held stable by the source from the accept edge until out_valid rises.
REQ-022 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11B; all byte arithmetic is 8-bit, with no carries.

Reset
REQ-023 While rst_n=0: FSM=IDLE, cnt=0, state=0, data_out=0, out_valid=0, busy=0, in_ready=1, effective immediately (asynchronous).
REQ-024 Reset asserted mid-operation SHALL abort the block with no partial output; the first accept after deassertion SHALL behave as from power-up.
REQ-025 Reset SHALL be released synchronously by the integrator; the core adds no internal synchronizer.

Configuration
REQ-026 With macro AES_KEY_LATCH_EN defined, the core SHALL copy round_keys into an internal register at the accept edge, use only that copy, and drop REQ-021.
REQ-027 Without AES_KEY_LATCH_EN, round_keys SHALL be read combinationally each round, with no key register.

Structure
REQ-028 Package aes_pkg SHALL hold Nb=4, the 128-bit block width constant, the FSM state encodings and the xtime function.
REQ-029 Sub-module aes_sbox (8-bit in, 8-bit out, combinational, FIPS-197 forward S-box) SHALL be instantiated 16 times for SubBytes.
REQ-030 Round datapath, FSM and counter SHALL reside in aes_cipher_iter.
REQ-031 A parameter check SHALL flag Nr != Nk+6 at elaboration.

Verification
REQ-032 Nk=4, key 000102030405060708090a0b0c0d0e0f expanded by keyExpansion, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
REQ-033 Nk=8, key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, out_valid 14 cycles after accept.
REQ-034 Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-035 out_ready held low 5 cycles in DONE -> data_out and out_valid stable, in_ready=0; second in_valid ignored until the cycle after the out_ready handshake.
REQ-036 rst_n pulsed low at round 5 -> out_valid=0, data_out=0, in_ready=1 immediately; a following encryption returns the correct ciphertext.
REQ-037 With AES_KEY_LATCH_EN, round_keys changed to all-zero one cycle after accept -> ciphertext still matches REQ-032.

Source files
------------

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared constants, FSM state encoding and GF(2^8) helpers for the iterative
// AES encryption core.
//   NB       : number of 32-bit columns in the AES state (always 4)
//   BLOCK_W  : width of one data block / one round key in bits
//   state_e  : FSM states of aes_cipher_iter
//   xtime()  : multiply a byte by {02} in GF(2^8), reduction polynomial 0x11B
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int NB      = 4;
    localparam int BLOCK_W = 32 * NB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Shift left by one; when the top bit falls out, fold it back in with 0x1B
    // (the low byte of 0x11B). Pure 8-bit XOR arithmetic, no carries.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ----------------------------------------------------------------------------
// aes_sbox
// Combinational FIPS-197 forward S-box (SubBytes for one byte).
// Ports:
//   i_byte : input  [7:0]  byte to substitute
//   o_byte : output [7:0]  S-box value of i_byte
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row-major table, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i sits at bit offset 8*(255-i), and 255-i is simply ~i.
    assign o_byte = SBOX_TBL[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_iter.sv
// ----------------------------------------------------------------------------
// aes_cipher_iter
// Iterative AES encryption core: one full round per clock, Nr cycles from
// accept to out_valid. Round keys are supplied pre-expanded on round_keys.
// Optional build macro:
//   AES_KEY_LATCH_EN : copy round_keys into an internal register at the accept
//                      edge so the source may change during the rounds.
// Parameters:
//   Nk : key length in 32-bit words (4, 6 or 8)
//   Nr : number of rounds, must equal Nk+6
// Ports:
//   clk        : input   clock, rising edge
//   rst_n      : input   asynchronous active-low reset
//   in_valid   : input   data_in / round_keys valid
//   in_ready   : output  core accepts a block this cycle (IDLE)
//   data_in    : input   [127:0] plaintext, byte 0 in [127:120]
//   round_keys : input   [128*(Nr+1)-1:0] expanded key, round key 0 on top
//   out_valid  : output  data_out holds a finished ciphertext (DONE)
//   out_ready  : input   consumer takes data_out
//   data_out   : output  [127:0] ciphertext
//   busy       : output  high while rounds are being computed
// ----------------------------------------------------------------------------
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 8,
    parameter int Nr = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BLOCK_W-1:0]         data_in,
    input  logic [BLOCK_W*(Nr+1)-1:0]  round_keys,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_W-1:0]         data_out,
    output logic                       busy
);

    localparam int         KEY_W    = BLOCK_W * (Nr + 1);
    localparam int         NBYTES   = 4 * NB;
    localparam logic [3:0] LAST_CNT = 4'(Nr);

    generate
        if (Nr != Nk + 6) begin : g_bad_nr
            $error("aes_cipher_iter: Nr (%0d) must equal Nk+6 (Nk=%0d)", Nr, Nk);
        end
        if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
            $error("aes_cipher_iter: Nk (%0d) must be 4, 6 or 8", Nk);
        end
    endgenerate

    state_e               r_state;
    logic [3:0]           r_cnt;
    logic [BLOCK_W-1:0]   r_blk;
    logic [BLOCK_W-1:0]   r_data_out;
    logic                 r_out_valid;
    logic                 r_in_ready;
    logic                 r_busy;

    logic [KEY_W-1:0]     w_key_src;
    logic [BLOCK_W-1:0]   w_rk_arr [0:Nr];
    logic [BLOCK_W-1:0]   w_rk;
    logic [7:0]           w_sb [NBYTES];
    logic [BLOCK_W-1:0]   w_sr_blk;
    logic [BLOCK_W-1:0]   w_mc_blk;
    logic [BLOCK_W-1:0]   w_round;
    logic                 w_accept;

    assign w_accept = (r_state == ST_IDLE) && in_valid;

    // ------------------------------------------------------------------
    // Key source: either the live input or a copy taken at accept.
    // ------------------------------------------------------------------
`ifdef AES_KEY_LATCH_EN
    logic [KEY_W-1:0] r_keys;

    // NOTE: wide data storage with no reset; it is only read after being
    // loaded at accept, so resetting it would add fan-out and buy nothing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_keys <= round_keys;
        end
    end

    assign w_key_src = r_keys;
`else
    assign w_key_src = round_keys;
`endif

    generate
        for (genvar r = 0; r <= Nr; r++) begin : g_rk
            assign w_rk_arr[r] = w_key_src[KEY_W-1-BLOCK_W*r -: BLOCK_W];
        end
    endgenerate

    assign w_rk = w_rk_arr[r_cnt];

    // ------------------------------------------------------------------
    // SubBytes + ShiftRows. Byte k is row k%4, column k/4; row r of the
    // output takes its byte from column (c+r) mod 4 of the input.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NBYTES; k++) begin : g_byte
            localparam int ROW = k % 4;
            localparam int COL = k / 4;
            localparam int SRC = 4 * ((COL + ROW) % NB) + ROW;

            aes_sbox u_sbox (
                .i_byte (r_blk[BLOCK_W-1-8*k -: 8]),
                .o_byte (w_sb[k])
            );

            assign w_sr_blk[BLOCK_W-1-8*k -: 8] = w_sb[SRC];
        end
    endgenerate

    // ------------------------------------------------------------------
    // MixColumns: each column times the fixed matrix [2 3 1 1] rotated.
    // {03}*a is computed as xtime(a)^a.
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < NB; c++) begin : g_col
            logic [7:0] w_a0, w_a1, w_a2, w_a3;

            assign w_a0 = w_sr_blk[BLOCK_W-1-32*c      -: 8];
            assign w_a1 = w_sr_blk[BLOCK_W-1-32*c - 8  -: 8];
            assign w_a2 = w_sr_blk[BLOCK_W-1-32*c - 16 -: 8];
            assign w_a3 = w_sr_blk[BLOCK_W-1-32*c - 24 -: 8];

            assign w_mc_blk[BLOCK_W-1-32*c      -: 8] =
                xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign w_mc_blk[BLOCK_W-1-32*c - 8  -: 8] =
                w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign w_mc_blk[BLOCK_W-1-32*c - 16 -: 8] =
                w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign w_mc_blk[BLOCK_W-1-32*c - 24 -: 8] =
                xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

    // The final round skips MixColumns.
    // NOTE: the default assignment first guarantees the output is driven on
    // every path, so no latch can be inferred.
    always_comb begin
        w_round = w_mc_blk ^ w_rk;
        if (r_cnt == LAST_CNT) begin
            w_round = w_sr_blk ^ w_rk;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Round key 0 comes straight from the input, which is
                        // valid at this edge in both key modes.
                        r_blk      <= data_in ^ round_keys[KEY_W-1 -: BLOCK_W];
                        r_cnt      <= 4'd1;
                        r_state    <= ST_ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_blk <= w_round;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt       <= '0;
                        r_data_out  <= w_round;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    // A simultaneous in_valid is deliberately not looked at
                    // here; the next block is taken from IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// ----------------------------------------------------------------------------
// tb_aes_cipher_iter
// Bench for aes_cipher_iter: an AES-128 instance (Nk=4) and an AES-256
// instance (Nk=8) share clock and reset. Round keys are expanded here from
// the cipher key using an S-box built from the GF(2^8) inverse plus the
// affine map. Expected ciphertexts are known-answer constants pushed to a
// per-instance queue at accept and compared when the core hands out a block.
// Inputs change 1 ns after the rising edge; the output monitor samples on the
// falling edge.
// Honours AES_KEY_LATCH_EN (adds the key-change-after-accept scenario).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_cipher_iter;

    localparam int W4 = 128 * 11;
    localparam int W8 = 128 * 15;

    logic clk;
    logic rst_n;

    logic            in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [127:0]    data_in4, data_out4;
    logic [W4-1:0]   rk4;

    logic            in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [127:0]    data_in8, data_out8;
    logic [W8-1:0]   rk8;

    aes_cipher_iter #(.Nk(4), .Nr(10)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .data_in    (data_in4),
        .round_keys (rk4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .data_out   (data_out4),
        .busy       (busy4)
    );

    aes_cipher_iter #(.Nk(8), .Nr(14)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .data_in    (data_in8),
        .round_keys (rk8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .data_out   (data_out8),
        .busy       (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    logic [127:0] sb4 [$];
    logic [127:0] sb8 [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid4 && out_ready4) begin
            if (sb4.size() == 0) check("sb4_extra", 128'(sb4.size()), 128'd1);
            else check("ct4", data_out4, sb4.pop_front());
        end
        if (out_valid8 && out_ready8) begin
            if (sb8.size() == 0) check("sb8_extra", 128'(sb8.size()), 128'd1);
            else check("ct8", data_out8, sb8.pop_front());
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference key expansion
    // ------------------------------------------------------------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h00;
            if (v != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; result holds round key r at
    // [W8-1-128*r -: 128], so an AES-128 schedule is the top W4 bits.
    task automatic expand(input logic [255:0] key, input int nk, output logic [W8-1:0] rk_all);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          total;
        total  = 4 * (nk + 7);
        rk_all = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) rk_all[W8-1-32*i -: 32] = w[i];
    endtask

    // ------------------------------------------------------------------
    // Drive helpers (all return 1 ns after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [127:0] pt, input logic [W4-1:0] rk,
                          input logic [127:0] exp, input bit push);
        check("rdy4_pre", 128'(in_ready4), 128'd1);
        data_in4  = pt;
        rk4       = rk;
        in_valid4 = 1'b1;
        tick();
        if (push) sb4.push_back(exp);
        in_valid4 = 1'b0;
        check("busy4", 128'(busy4), 128'd1);
    endtask

    // Called `done` edges after the accept edge; checks out_valid rises on
    // exactly the 10th.
    task automatic wait_done4(input int done);
        repeat (9 - done) tick();
        check("lat4_early", 128'(out_valid4), 128'd0);
        tick();
        check("lat4", 128'(out_valid4), 128'd1);
    endtask

    task automatic drain4();
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("idle4_rdy", 128'(in_ready4), 128'd1);
        check("idle4_ov", 128'(out_valid4), 128'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_A8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B4 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic [W8-1:0] rk_all;
    logic [W4-1:0] rk_a4, rk_b4;
    logic [W8-1:0] rk_a8;

    initial begin
        rst_n      = 1'b0;
        in_valid4  = 1'b0; out_ready4 = 1'b0; data_in4 = '0; rk4 = '0;
        in_valid8  = 1'b0; out_ready8 = 1'b0; data_in8 = '0; rk8 = '0;

        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, rk_all);
        rk_a4 = rk_all[W8-1 -: W4];
        expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, rk_all);
        rk_b4 = rk_all[W8-1 -: W4];
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, rk_a8);

        // Reset state
        repeat (2) tick();
        check("rst_rdy4", 128'(in_ready4), 128'd1);
        check("rst_ov4", 128'(out_valid4), 128'd0);
        check("rst_do4", data_out4, 128'd0);
        check("rst_busy4", 128'(busy4), 128'd0);
        check("rst_do8", data_out8, 128'd0);
        check("rst_rdy8", 128'(in_ready8), 128'd1);
        rst_n = 1'b1;
        tick();

        // AES-128 vector; in_valid with junk data during rounds is ignored
        start4(PT_A, rk_a4, CT_A4, 1'b1);
        in_valid4 = 1'b1;
        data_in4  = ~PT_A;
        repeat (5) tick();
        in_valid4 = 1'b0;
        wait_done4(5);

        // Hold in DONE for 5 cycles with a second block already offered
        data_in4  = PT_B;
        rk4       = rk_b4;
        in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_ov4", 128'(out_valid4), 128'd1);
            check("hold_rdy4", 128'(in_ready4), 128'd0);
            check("hold_do4", data_out4, CT_A4);
            tick();
        end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("ret_rdy4", 128'(in_ready4), 128'd1);
        check("ret_ov4", 128'(out_valid4), 128'd0);
        check("ret_busy4", 128'(busy4), 128'd0);
        tick();
        sb4.push_back(CT_B4);
        in_valid4 = 1'b0;
        check("acc2_busy4", 128'(busy4), 128'd1);
        wait_done4(0);
        drain4();

        // AES-256 vector
        check("rdy8_pre", 128'(in_ready8), 128'd1);
        data_in8  = PT_A;
        rk8       = rk_a8;
        in_valid8 = 1'b1;
        tick();
        sb8.push_back(CT_A8);
        in_valid8 = 1'b0;
        repeat (13) tick();
        check("lat8_early", 128'(out_valid8), 128'd0);
        tick();
        check("lat8", 128'(out_valid8), 128'd1);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("idle8_rdy", 128'(in_ready8), 128'd1);

        // Reset in the middle of a block, then a clean encryption
        start4(PT_A, rk_a4, CT_A4, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("arst_ov4", 128'(out_valid4), 128'd0);
        check("arst_do4", data_out4, 128'd0);
        check("arst_rdy4", 128'(in_ready4), 128'd1);
        check("arst_busy4", 128'(busy4), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start4(PT_B, rk_b4, CT_B4, 1'b1);
        wait_done4(0);
        drain4();

`ifdef AES_KEY_LATCH_EN
        // Keys removed right after accept; the latched copy must be used
        start4(PT_A, rk_a4, CT_A4, 1'b1);
        rk4 = '0;
        wait_done4(0);
        drain4();
`endif

        repeat (3) tick();
        check("sb4_left", 128'(sb4.size()), 128'd0);
        check("sb8_left", 128'(sb8.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
